// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared definitions for the unified-memory port arbiter:
//   - memory access-size encodings (same values the control unit drives
//     onto Mode for loads/stores)
//   - arbiter FSM state encoding
//   - alignment check, also reused by the exception logic
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam logic [2:0] MEM_W  = 3'd0;
  localparam logic [2:0] MEM_HW = 3'd1;
  localparam logic [2:0] MEM_B  = 3'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2,
    REJECT  = 2'd3
  } arb_state_t;

  // Word accesses need addr[1:0]==0, halfwords need addr[0]==0.
  // Byte accesses (and any unknown size) are never flagged.
  function automatic logic is_misaligned(input logic [2:0] mode,
                                         input logic [1:0] addr_lo);
    logic res;
    res = 1'b0;
    case (mode)
      MEM_W:   res = (addr_lo != 2'b00);
      MEM_HW:  res = addr_lo[0];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// ---------------------------------------------------------------------------
// mem_starve_counter
// Saturating counter of fetch cycles lost to data traffic.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_inc      count one blocked cycle (saturates at MAX)
//   i_clr      clear (wins over i_inc)
//   o_at_max   counter has reached MAX
// ---------------------------------------------------------------------------
module mem_starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam logic [3:0] LP_MAX = 4'(MAX);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_inc && (r_cnt != LP_MAX)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_at_max = (r_cnt == LP_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-ported unified memory between instruction fetch and
// load/store traffic. Data wins arbitration unless fetch has been blocked
// STARVE_MAX times in a row. One access is outstanding at a time; the memory
// command is held stable until mem_ready.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req/if_addr                fetch request (level) and address
//   if_gnt/if_valid/if_rdata      fetch grant pulse, data pulse, fetched word
//   d_rd/d_wr/d_addr/d_wdata/d_mode  load/store request and payload
//   d_gnt/d_valid/d_rdata/d_misalign data grant, completion, load data, reject
//   mem_en/mem_we/mem_addr/mem_wdata/mem_mode  memory command
//   mem_rdata/mem_ready           memory response
//   busy                          arbiter not idle (pipeline stall)
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_mode,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_misalign,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_mode,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  arb_state_t        r_state, w_state_next;
  logic              r_mem_en, w_mem_en_next;
  logic              r_mem_we, w_mem_we_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;
  logic [2:0]        r_mem_mode, w_mem_mode_next;
  logic              r_if_gnt, w_if_gnt_next;
  logic              r_if_valid, w_if_valid_next;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_next;
  logic              r_d_gnt, w_d_gnt_next;
  logic              r_d_valid, w_d_valid_next;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata_next;
  logic              r_d_misalign, w_d_misalign_next;

  logic w_d_req, w_fetch_win, w_misalign;
  logic w_starve_inc, w_starve_clr, w_starve_max;

  assign w_d_req     = d_rd | d_wr;
  assign w_fetch_win = if_req & (~w_d_req | w_starve_max);
  assign w_misalign  = is_misaligned(d_mode, d_addr[1:0]);

  mem_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (w_starve_inc),
    .i_clr    (w_starve_clr),
    .o_at_max (w_starve_max)
  );

  always_comb begin
    w_state_next      = r_state;
    w_mem_en_next     = r_mem_en;
    w_mem_we_next     = r_mem_we;
    w_mem_addr_next   = r_mem_addr;
    w_mem_wdata_next  = r_mem_wdata;
    w_mem_mode_next   = r_mem_mode;
    w_if_gnt_next     = 1'b0;
    w_if_valid_next   = 1'b0;
    w_if_rdata_next   = r_if_rdata;
    w_d_gnt_next      = 1'b0;
    w_d_valid_next    = 1'b0;
    w_d_rdata_next    = r_d_rdata;
    w_d_misalign_next = 1'b0;
    w_starve_inc      = 1'b0;
    w_starve_clr      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_fetch_win) begin
          w_state_next    = BUSY_IF;
          w_if_gnt_next   = 1'b1;
          w_mem_en_next   = 1'b1;
          w_mem_we_next   = 1'b0;
          w_mem_addr_next = if_addr;
          w_mem_mode_next = MEM_W;
          w_starve_clr    = 1'b1;
        end else if (w_d_req) begin
          w_d_gnt_next = 1'b1;
          // A fetch losing to data counts as one blocked cycle.
          w_starve_inc = if_req;
          if (w_misalign) begin
            // Rejected accesses never reach the memory.
            w_state_next = REJECT;
          end else begin
            w_state_next     = BUSY_D;
            w_mem_en_next    = 1'b1;
            w_mem_we_next    = d_wr;  // store wins if both rd and wr are set
            w_mem_addr_next  = d_addr;
            w_mem_wdata_next = d_wdata;
            w_mem_mode_next  = d_mode;
          end
        end
      end
      BUSY_IF: begin
        if (mem_ready) begin
          w_state_next    = IDLE;
          w_mem_en_next   = 1'b0;
          w_mem_we_next   = 1'b0;
          w_if_rdata_next = mem_rdata;
          w_if_valid_next = 1'b1;
        end
      end
      BUSY_D: begin
        // Every cycle a data access occupies the port also blocks fetch.
        w_starve_inc = if_req;
        if (mem_ready) begin
          w_state_next   = IDLE;
          w_mem_en_next  = 1'b0;
          w_mem_we_next  = 1'b0;
          w_d_valid_next = 1'b1;
          if (!r_mem_we) begin
            w_d_rdata_next = mem_rdata;
          end
        end
      end
      REJECT: begin
        w_state_next      = IDLE;
        w_d_valid_next    = 1'b1;
        w_d_misalign_next = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_mode   <= 3'd0;
      r_if_gnt     <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_rdata   <= '0;
      r_d_gnt      <= 1'b0;
      r_d_valid    <= 1'b0;
      r_d_rdata    <= '0;
      r_d_misalign <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_mem_en     <= w_mem_en_next;
      r_mem_we     <= w_mem_we_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_wdata  <= w_mem_wdata_next;
      r_mem_mode   <= w_mem_mode_next;
      r_if_gnt     <= w_if_gnt_next;
      r_if_valid   <= w_if_valid_next;
      r_if_rdata   <= w_if_rdata_next;
      r_d_gnt      <= w_d_gnt_next;
      r_d_valid    <= w_d_valid_next;
      r_d_rdata    <= w_d_rdata_next;
      r_d_misalign <= w_d_misalign_next;
    end
  end

  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_mode   = r_mem_mode;
  assign if_gnt     = r_if_gnt;
  assign if_valid   = r_if_valid;
  assign if_rdata   = r_if_rdata;
  assign d_gnt      = r_d_gnt;
  assign d_valid    = r_d_valid;
  assign d_rdata    = r_d_rdata;
  assign d_misalign = r_d_misalign;
  assign busy       = (r_state != IDLE);

endmodule
